// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: CPU request/response and word-memory bus bundle; slave = lsu_ctrl, master = CPU/memory side
interface lsu_ctrl_if #(parameter int ADDR_W = 12);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [2:0] req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic resp_valid;
  logic [31:0] resp_data;
  logic resp_err;
  logic busy;
  logic [ADDR_W-3:0] data_addr;
  logic ren;
  logic wen;
  logic [31:0] data_in;
  logic [3:0] byte_select_vector;
  logic [31:0] data_out;
  logic ready;
  modport slave (
    input req_valid, req_we, req_funct3, req_addr, req_wdata, data_out, ready,
    output req_ready, resp_valid, resp_data, resp_err, busy, data_addr, ren, wen, data_in, byte_select_vector
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, data_out, ready,
    input req_ready, resp_valid, resp_data, resp_err, busy, data_addr, ren, wen, data_in, byte_select_vector
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RISC-V load/store unit FSM; clk/reset plus bus (CPU req/resp, memory ren/wen/lanes/data/ready)
module lsu_ctrl #(
  parameter int ADDR_W = 12,
  parameter int TIMEOUT = 31
) (
  input logic clk,
  input logic reset,
  lsu_ctrl_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;
  state_t state;
  logic [1:0] lo;
  logic [2:0] f3;
  logic [CW-1:0] cnt;
  logic bad;
  logic [3:0] st_bsv;
  logic [31:0] st_data;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  assign bus.req_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bad = bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11 ||
               (bus.req_we && bus.req_funct3[2]) ||
               (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
               (bus.req_funct3 == 3'b010 && bus.req_addr[1:0] != 2'b00);
  assign st_bsv = bus.req_funct3[1] ? 4'b1111 :
                  bus.req_funct3[0] ? (bus.req_addr[1] ? 4'b1100 : 4'b0011) :
                  4'b0001 << bus.req_addr[1:0];
  assign st_data = bus.req_funct3[1] ? bus.req_wdata :
                   bus.req_funct3[0] ? {2{bus.req_wdata[15:0]}} : {4{bus.req_wdata[7:0]}};
  assign ld_b = bus.data_out[{lo, 3'b000} +: 8];
  assign ld_h = lo[1] ? bus.data_out[31:16] : bus.data_out[15:0];
  assign ld_data = f3[1] ? bus.data_out :
                   f3[0] ? {{16{~f3[2] & ld_h[15]}}, ld_h} : {{24{~f3[2] & ld_b[7]}}, ld_b};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      lo <= '0;
      f3 <= '0;
      cnt <= '0;
      bus.ren <= 1'b0;
      bus.wen <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err <= 1'b0;
      bus.resp_data <= '0;
      bus.data_addr <= '0;
      bus.data_in <= '0;
      bus.byte_select_vector <= '0;
    end else begin
      bus.ren <= 1'b0;
      bus.wen <= 1'b0;
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          bus.data_addr <= bus.req_addr[ADDR_W-1:2];
          lo <= bus.req_addr[1:0];
          f3 <= bus.req_funct3;
          cnt <= '0;
          if (bad) begin
            state <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err <= 1'b1;
            bus.resp_data <= '0;
            bus.data_in <= '0;
            bus.byte_select_vector <= '0;
          end else if (bus.req_we) begin
            state <= WR_REQ;
            bus.wen <= 1'b1;
            bus.data_in <= st_data;
            bus.byte_select_vector <= st_bsv;
          end else begin
            state <= RD_REQ;
            bus.ren <= 1'b1;
            bus.data_in <= '0;
            bus.byte_select_vector <= 4'b1111;
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          cnt <= cnt + 1'b1;
          // memory has not yet dropped ready in the first wait cycle, so it is stale there
          if (cnt != '0 && bus.ready) begin
            state <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err <= 1'b0;
            bus.resp_data <= ld_data;
          end else if (cnt == LAST) begin
            state <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err <= 1'b1;
            bus.resp_data <= '0;
          end
        end
        WR_REQ: begin
          state <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err <= 1'b0;
          bus.resp_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven directed checks of lsu_ctrl against a 7-cycle-latency memory model
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic stall;
  logic [31:0] mem_word;
  int lat_cnt;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  lsu_ctrl_if #(.ADDR_W(12)) bus ();
  lsu_ctrl #(.ADDR_W(12), .TIMEOUT(31)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  assign bus.data_out = mem_word;
  always @(posedge clk) begin
    if (reset) begin
      lat_cnt <= 0;
      bus.ready <= 1'b1;
    end else if (bus.ren) begin
      lat_cnt <= 7;
      bus.ready <= 1'b0;
    end else if (lat_cnt > 1) lat_cnt <= lat_cnt - 1;
    else begin
      lat_cnt <= 0;
      bus.ready <= !stall;
    end
  end
  typedef struct {
    logic we;
    logic [2:0] f3;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic stall;
    logic err;
    logic [31:0] data;
    logic [3:0] bsv;
    logic [31:0] din;
    int lat;
    int rens;
    int wens;
  } vec_t;
  vec_t vecs[15];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input string nm);
    int k, rn, wn;
    logic [31:0] b, di, da;
    logic stable, seen;
    @(negedge clk);
    chk({nm, ".req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    stall = v.stall;
    bus.req_valid = 1'b1;
    bus.req_we = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr = v.addr;
    bus.req_wdata = v.wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rn = 0;
    wn = 0;
    seen = 1'b0;
    stable = 1'b1;
    k = 1;
    b = {28'd0, bus.byte_select_vector};
    di = bus.data_in;
    da = {22'd0, bus.data_addr};
    while (!seen && k < 60) begin
      rn += int'(bus.ren);
      wn += int'(bus.wen);
      if ({28'd0, bus.byte_select_vector} !== b || bus.data_in !== di || {22'd0, bus.data_addr} !== da) stable = 1'b0;
      if (bus.resp_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk({nm, ".latency"}, seen ? k : 0, v.lat);
    chk({nm, ".resp_err"}, {31'd0, bus.resp_err}, {31'd0, v.err});
    chk({nm, ".resp_data"}, bus.resp_data, v.data);
    chk({nm, ".ren_cycles"}, rn, v.rens);
    chk({nm, ".wen_cycles"}, wn, v.wens);
    if (!v.err) begin
      chk({nm, ".bsv"}, b, {28'd0, v.bsv});
      chk({nm, ".data_addr"}, da, {22'd0, v.addr[11:2]});
      chk({nm, ".stable"}, {31'd0, stable}, 32'd1);
      if (v.we) chk({nm, ".data_in"}, di, v.din);
    end
    @(negedge clk);
    chk({nm, ".post_valid_ready"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
    chk({nm, ".resp_data_hold"}, bus.resp_data, v.data);
  endtask
  initial begin
    vecs[0]  = '{1'b1, 3'b010, 12'h010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        4'b1111, 32'hDEADBEEF, 2,  0, 1};
    vecs[1]  = '{1'b1, 3'b000, 12'h013, 32'h000000A5, 1'b0, 1'b0, 32'h0,        4'b1000, 32'hA5A5A5A5, 2,  0, 1};
    vecs[2]  = '{1'b1, 3'b001, 12'h012, 32'h00001234, 1'b0, 1'b0, 32'h0,        4'b1100, 32'h12341234, 2,  0, 1};
    vecs[3]  = '{1'b0, 3'b000, 12'h013, 32'h0,        1'b0, 1'b0, 32'hFFFFFF80, 4'b1111, 32'h0,        10, 1, 0};
    vecs[4]  = '{1'b0, 3'b100, 12'h013, 32'h0,        1'b0, 1'b0, 32'h00000080, 4'b1111, 32'h0,        10, 1, 0};
    vecs[5]  = '{1'b0, 3'b001, 12'h010, 32'h0,        1'b0, 1'b0, 32'h00007F01, 4'b1111, 32'h0,        10, 1, 0};
    vecs[6]  = '{1'b0, 3'b101, 12'h012, 32'h0,        1'b0, 1'b0, 32'h000080FF, 4'b1111, 32'h0,        10, 1, 0};
    vecs[7]  = '{1'b0, 3'b010, 12'h002, 32'h0,        1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        1,  0, 0};
    vecs[8]  = '{1'b0, 3'b011, 12'h010, 32'h0,        1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        1,  0, 0};
    vecs[9]  = '{1'b0, 3'b010, 12'h010, 32'h0,        1'b1, 1'b1, 32'h0,        4'b1111, 32'h0,        33, 1, 0};
    vecs[10] = '{1'b1, 3'b100, 12'h010, 32'h000000A5, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        1,  0, 0};
    vecs[11] = '{1'b1, 3'b001, 12'h011, 32'h00001234, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        1,  0, 0};
    vecs[12] = '{1'b0, 3'b010, 12'h010, 32'h0,        1'b0, 1'b0, 32'h80FF7F01, 4'b1111, 32'h0,        10, 1, 0};
    vecs[13] = '{1'b0, 3'b001, 12'h012, 32'h0,        1'b0, 1'b0, 32'hFFFF80FF, 4'b1111, 32'h0,        10, 1, 0};
    vecs[14] = '{1'b1, 3'b000, 12'h001, 32'h0000005A, 1'b0, 1'b0, 32'h0,        4'b0010, 32'h5A5A5A5A, 2,  0, 1};
    mem_word = 32'h80FF7F01;
    stall = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset.ctrl", {27'd0, bus.ren, bus.wen, bus.resp_valid, bus.resp_err, bus.busy}, 32'd0);
    chk("reset.req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset.lanes", {18'd0, bus.data_addr, bus.byte_select_vector}, 32'd0);
    chk("reset.data", bus.data_in | bus.resp_data, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) run(vecs[i], $sformatf("vec%0d", i));
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr = 12'h010;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("midrst.busy_before", {31'd0, bus.busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst.ren_busy_valid_ready", {28'd0, bus.ren, bus.busy, bus.resp_valid, bus.req_ready}, 32'd1);
    chk("midrst.data_addr", {22'd0, bus.data_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run('{1'b1, 3'b010, 12'h000, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 4'b1111, 32'hCAFEF00D, 2, 0, 1}, "after_reset_sw");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address width; memory word address is ADDR_W-2 bits.
REQ-002 SHALL have parameter TIMEOUT, default 31, max RD_WAIT cycles before error; counter width $clog2(TIMEOUT+1).
REQ-003 SHALL have one clock and an asynchronous active-high reset, clock `clk` and reset `reset`.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  async active-high reset.
REQ-006 req_valid  in  1  CPU load/store request.
REQ-007 req_ready  out  1  high iff state IDLE; request accepted on req_valid&&req_ready.
REQ-008 req_we  in  1  1=store, 0=load.
REQ-009 req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  32  store data, LSB-justified.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_data  out  32  load result, extended; 0 for stores and errors.
REQ-014 resp_err  out  1  qualified by resp_valid; misaligned, illegal funct3 or timeout.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 data_addr  out  ADDR_W-2  word address, req_addr[ADDR_W-1:2].
REQ-017 ren / wen  out  1 each  memory read/write strobes; never both high.
REQ-018 data_in  out  32  lane-aligned store data.
REQ-019 byte_select_vector  out  4  byte-lane write enables.
REQ-020 data_out  in  32  memory read word.
REQ-021 ready  in  1  memory ready; low while a read is in progress, high when data_out is valid.

Function
REQ-022 SHALL implement states IDLE, RD_REQ, RD_WAIT, WR_REQ and RESP.
REQ-023 On accept SHALL register addr, we, funct3 and wdata; data_addr, data_in and byte_select_vector SHALL hold stable until return to IDLE.
REQ-024 Misalignment SHALL be H/HU with addr[0]=1, or W with addr[1:0]!=0.
REQ-025 Illegal funct3 SHALL be 011, 11x, or a store with funct3[2]=1.
REQ-026 A misaligned or illegal request SHALL go IDLE->RESP, assert resp_err, and never assert ren or wen.
REQ-027 A legal store SHALL go IDLE->WR_REQ (wen high exactly 1 cycle)->RESP, without waiting on ready; resp_valid SHALL be 2 cycles after accept.
REQ-028 Store lanes SHALL be: B bsv=1<<addr[1:0] with data_in = byte x4; H bsv=0011 (addr[1]=0) or 1100 with data_in = half x2; W bsv=1111 with data_in=wdata.
REQ-029 A legal load SHALL go IDLE->RD_REQ (ren high exactly 1 cycle, bsv=1111)->RD_WAIT.
REQ-030 RD_WAIT SHALL ignore ready in its first cycle, then capture data_out on the first ready==1 and go to RESP.
REQ-031 Load extraction SHALL select lane addr[1:0] (B/BU) or half addr[1] (H/HU); B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-032 RD_WAIT SHALL count cycles; if the count reaches TIMEOUT without capture, it SHALL go to RESP with resp_err=1 and resp_data=0.
REQ-033 RESP SHALL last exactly 1 cycle: resp_valid=1, then IDLE; a new request is accepted the following cycle at earliest.
REQ-034 resp_data and resp_err SHALL hold their value until the next RESP; resp_valid SHALL be low outside RESP.
REQ-035 req_valid SHALL be ignored while busy; there is no queueing.

Reset
REQ-036 While reset is high, regardless of clk, SHALL force: state IDLE; ren, wen, resp_valid, resp_err and busy 0; req_ready 1; data_addr, data_in, byte_select_vector, resp_data and timeout counter 0.
REQ-037 Reset mid-transaction SHALL abandon the access with no response pulse; first request after release SHALL be accepted normally.

Verification
REQ-038 sw addr 0x010 data 0xDEADBEEF -> wen 1 cycle, data_addr=4, bsv=1111, data_in=0xDEADBEEF; resp_valid 2 cycles after accept, err=0.
REQ-039 sb addr 0x013 data 0x000000A5 -> bsv=1000, data_in=0xA5A5A5A5; sh addr 0x012 data 0x1234 -> bsv=1100, data_in=0x12341234.
REQ-040 Memory word 0x80FF7F01 at word 4, 7-cycle read latency: lb 0x013 -> 0xFFFFFF80; lbu 0x013 -> 0x00000080; lh 0x010 -> 0x00007F01; lhu 0x012 -> 0x000080FF.
REQ-041 lw 0x002 -> resp_err=1, resp_data=0, resp_valid 1 cycle after accept; funct3 011 gives the same; ren and wen stay 0.
REQ-042 Load with ready held 0 after issue -> resp_err=1, resp_data=0 after TIMEOUT RD_WAIT cycles; ren was high only 1 cycle.
REQ-043 Reset asserted in RD_WAIT -> ren, busy and resp_valid 0 immediately; after release, sw 0x000 completes in 2 cycles.
